// File: rtl/boot_pkg.sv
// Shared state encoding, output-flag bundle and default parameters for cpu_boot_ctrl.
package boot_pkg;

  localparam int unsigned DEF_IMEM_AW    = 8;
  localparam int unsigned DEF_DMEM_AW    = 8;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam logic [31:0] DEF_MAX_CYCLES = 32'd1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_TOUT
  } boot_state_t;

  typedef struct packed {
    logic core_rst;
    logic busy;
    logic done;
    logic timeout;
    logic ld_ready;
  } boot_flags_t;

  // Output flags are a pure function of the state being entered, so they are
  // registered together with the state register.
  function automatic boot_flags_t flags_of(boot_state_t s);
    boot_flags_t f;
    f.core_rst = (s == S_RUN);
    f.busy     = (s == S_LOAD) || (s == S_RUN);
    f.done     = (s == S_DONE);
    f.timeout  = (s == S_TOUT);
    f.ld_ready = (s == S_LOAD);
    return f;
  endfunction

endpackage

// File: rtl/boot_addr_cnt.sv
// Image-load address counter: counts up to depth-1, then latches full instead of wrapping.
module boot_addr_cnt #(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] cnt,
  output logic          full
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      full <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      full <= 1'b0;
    end else if (inc && !full) begin
      // The word at the top address is written once; after that we hold.
      if (&cnt) full <= 1'b1;
      else      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot controller: streams an image into imem/dmem, then releases the core until halt.
// Define BOOT_CYCLE_LIMIT_EN to add the run-cycle counter and MAX_CYCLES timeout.
//
// state | meaning
// IDLE  | after reset, waiting for start
// LOAD  | accepting image words, core held in reset
// RUN   | core released, waiting for core_halt
// DONE  | core halted, core held in reset
// TOUT  | run limit reached without halt
module cpu_boot_ctrl
  import boot_pkg::*;
#(
  parameter int unsigned IMEM_AW    = DEF_IMEM_AW,
  parameter int unsigned DMEM_AW    = DEF_DMEM_AW,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter logic [31:0] MAX_CYCLES = DEF_MAX_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [DATA_W-1:0]  ld_data,
  input  logic               ld_sel,
  input  logic               ld_last,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [DATA_W-1:0]  imem_wdata,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic               core_rst,
  input  logic               core_halt,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               ld_err,
  output logic [31:0]        cycle_count
);

  boot_state_t        state;
  boot_flags_t        flags;
  logic               clr_session;
  logic               accept;
  logic               at_limit;
  logic [IMEM_AW-1:0] icnt;
  logic [DMEM_AW-1:0] dcnt;
  logic               ifull;
  logic               dfull;

  assign clr_session = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_TOUT));
  assign accept      = flags.ld_ready && ld_valid;

  assign core_rst = flags.core_rst;
  assign busy     = flags.busy;
  assign done     = flags.done;
  assign timeout  = flags.timeout;
  assign ld_ready = flags.ld_ready;

  boot_addr_cnt #(.AW(IMEM_AW)) u_icnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_session),
    .inc  (accept && !ld_sel),
    .cnt  (icnt),
    .full (ifull)
  );

  boot_addr_cnt #(.AW(DMEM_AW)) u_dcnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_session),
    .inc  (accept && ld_sel),
    .cnt  (dcnt),
    .full (dfull)
  );

`ifdef BOOT_CYCLE_LIMIT_EN
  logic [31:0] cyc_q;

  assign at_limit    = (cyc_q >= MAX_CYCLES);
  assign cycle_count = cyc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
    end else if (clr_session) begin
      cyc_q <= '0;
    end else if ((state == S_RUN) && !core_halt && !at_limit && (cyc_q != 32'hFFFF_FFFF)) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end
`else
  logic unused_max_cycles;

  assign unused_max_cycles = ^MAX_CYCLES;
  assign at_limit          = 1'b0;
  assign cycle_count       = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      flags      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      ld_err     <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      dmem_we <= 1'b0;

      // Write lands one cycle after acceptance; a full memory drops the word.
      if (accept) begin
        if (!ld_sel) begin
          if (ifull) begin
            ld_err <= 1'b1;
          end else begin
            imem_we    <= 1'b1;
            imem_addr  <= icnt;
            imem_wdata <= ld_data;
          end
        end else begin
          if (dfull) begin
            ld_err <= 1'b1;
          end else begin
            dmem_we    <= 1'b1;
            dmem_addr  <= dcnt;
            dmem_wdata <= ld_data;
          end
        end
      end

      case (state)
        S_IDLE, S_DONE, S_TOUT: begin
          if (start) begin
            state  <= S_LOAD;
            flags  <= flags_of(S_LOAD);
            ld_err <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept && ld_last) begin
            state <= S_RUN;
            flags <= flags_of(S_RUN);
          end
        end
        S_RUN: begin
          if (core_halt) begin
            state <= S_DONE;
            flags <= flags_of(S_DONE);
          end else if (at_limit) begin
            state <= S_TOUT;
            flags <= flags_of(S_TOUT);
          end
        end
        default: begin
          state <= S_IDLE;
          flags <= flags_of(S_IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Self-checking bench for cpu_boot_ctrl: directed scenarios plus randomized load/run sessions.
module tb_cpu_boot_ctrl;

  localparam int IAW    = 2;
  localparam int DAW    = 3;
  localparam int MAXC   = 20;
  localparam int IDEPTH = 1 << IAW;
  localparam int DDEPTH = 1 << DAW;
`ifdef BOOT_CYCLE_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           ld_valid = 1'b0;
  logic           ld_sel = 1'b0;
  logic           ld_last = 1'b0;
  logic           core_halt = 1'b0;
  logic [31:0]    ld_data = '0;
  logic           ld_ready, imem_we, dmem_we, core_rst, busy, done, timeout, ld_err;
  logic [IAW-1:0] imem_addr;
  logic [DAW-1:0] dmem_addr;
  logic [31:0]    imem_wdata, dmem_wdata, cycle_count;

  int n_chk = 0;
  int n_err = 0;

  // Reference model of the current session: words written per memory and sticky error.
  int ni, nd;
  bit exp_err;

  typedef struct {
    int          gap;
    bit          sel;
    logic [31:0] d;
  } word_t;
  word_t wq[$];

  cpu_boot_ctrl #(
    .IMEM_AW    (IAW),
    .DMEM_AW    (DAW),
    .DATA_W     (32),
    .MAX_CYCLES (MAXC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .ld_sel      (ld_sel),
    .ld_last     (ld_last),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .core_rst    (core_rst),
    .core_halt   (core_halt),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .ld_err      (ld_err),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ld_ready"}, ld_ready, 0);
    chk({tag, "_imem_we"}, imem_we, 0);
    chk({tag, "_imem_addr"}, imem_addr, 0);
    chk({tag, "_imem_wdata"}, imem_wdata, 0);
    chk({tag, "_dmem_we"}, dmem_we, 0);
    chk({tag, "_dmem_addr"}, dmem_addr, 0);
    chk({tag, "_dmem_wdata"}, dmem_wdata, 0);
    chk({tag, "_core_rst"}, core_rst, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_ld_err"}, ld_err, 0);
    chk({tag, "_cycle_count"}, cycle_count, 0);
  endtask

  task automatic add_word(input int gap, input bit sel, input logic [31:0] d);
    word_t w;
    w.gap = gap;
    w.sel = sel;
    w.d   = d;
    wq.push_back(w);
  endtask

  // Outside LOAD: valid traffic must never produce a write.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      ld_valid = $urandom_range(0, 1);
      ld_sel   = $urandom_range(0, 1);
      ld_last  = $urandom_range(0, 1);
      ld_data  = $urandom;
      @(negedge clk);
      chk("idle_imem_we", imem_we, 0);
      chk("idle_dmem_we", dmem_we, 0);
      chk("idle_busy", busy, 0);
    end
    ld_valid = 1'b0;
  endtask

  task automatic begin_session();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ni = 0;
    nd = 0;
    exp_err = 1'b0;
    chk("start_ld_ready", ld_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_ld_err", ld_err, 0);
    chk("start_cycle_count", cycle_count, 0);
    chk("start_core_rst", core_rst, 0);
    chk("start_done", done, 0);
    chk("start_timeout", timeout, 0);
  endtask

  task automatic load_cycle(input bit v, input bit sel, input bit last, input logic [31:0] d);
    bit          ew_i, ew_d;
    logic [63:0] ea;
    ew_i = 1'b0;
    ew_d = 1'b0;
    ea   = '0;
    ld_valid = v;
    ld_sel   = sel;
    ld_last  = last;
    ld_data  = d;
    start    = $urandom_range(0, 1);
    if (v) begin
      if (!sel) begin
        if (ni < IDEPTH) begin ew_i = 1'b1; ea = ni; ni++; end
        else exp_err = 1'b1;
      end else begin
        if (nd < DDEPTH) begin ew_d = 1'b1; ea = nd; nd++; end
        else exp_err = 1'b1;
      end
    end
    @(negedge clk);
    ld_valid = 1'b0;
    start    = 1'b0;
    chk("imem_we", imem_we, ew_i);
    chk("dmem_we", dmem_we, ew_d);
    if (ew_i) begin
      chk("imem_addr", imem_addr, ea);
      chk("imem_wdata", imem_wdata, d);
    end
    if (ew_d) begin
      chk("dmem_addr", dmem_addr, ea);
      chk("dmem_wdata", dmem_wdata, d);
    end
    chk("ld_err", ld_err, exp_err);
    chk("ld_ready", ld_ready, !(v && last));
    chk("load_core_rst", core_rst, v && last);
  endtask

  task automatic do_load();
    for (int i = 0; i < wq.size(); i++) begin
      for (int g = 0; g < wq[i].gap; g++)
        load_cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      load_cycle(1'b1, wq[i].sel, i == wq.size() - 1, wq[i].d);
    end
    wq.delete();
  endtask

  // Run phase model: cycle k of RUN shows count k; halt at k ends in DONE,
  // reaching the limit without halt ends in TOUT; the count then stays put.
  task automatic run_phase(input int halt_at);
    int k;
    bit fin, exp_done, exp_tout;
    k = 0;
    fin = 1'b0;
    exp_done = 1'b0;
    exp_tout = 1'b0;
    for (int n = 0; n < 200 && !fin; n++) begin
      chk("run_core_rst", core_rst, 1);
      chk("run_busy", busy, 1);
      chk("run_cycle_count", cycle_count, LIM ? k : 0);
      core_halt = (k == halt_at);
      start     = $urandom_range(0, 1);
      @(negedge clk);
      if (k == halt_at) begin
        exp_done = 1'b1;
        fin = 1'b1;
      end else if (LIM && k >= MAXC) begin
        exp_tout = 1'b1;
        fin = 1'b1;
      end else begin
        k++;
      end
    end
    core_halt = 1'b0;
    start     = 1'b0;
    if (!fin) chk("run_bound", 0, 1);
    chk("end_done", done, exp_done);
    chk("end_timeout", timeout, exp_tout);
    chk("end_core_rst", core_rst, 0);
    chk("end_busy", busy, 0);
    chk("end_cycle_count", cycle_count, LIM ? k : 0);
    chk("end_ld_err", ld_err, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b1;
    idle_cycles(3);

    // Three imem words back to back.
    for (int i = 0; i < 3; i++) add_word(0, 1'b0, 32'hA0 + i);
    begin_session();
    do_load();
    run_phase(3);

    // Interleaved imem/dmem with gaps.
    add_word(0, 1'b0, 32'h1111_0000);
    add_word(1, 1'b1, 32'h2222_0000);
    add_word(2, 1'b0, 32'h1111_0001);
    add_word(1, 1'b1, 32'h2222_0001);
    begin_session();
    do_load();
    run_phase(2);

    // Five imem words into a four-word memory, then halt at cycle 7.
    for (int i = 0; i < 5; i++) add_word(0, 1'b0, 32'hC0DE_0000 + i);
    begin_session();
    do_load();
    run_phase(7);
    idle_cycles(2);

    // Limit without halt, then halt exactly at the limit.
    add_word(0, 1'b1, 32'hDEAD_BEEF);
    begin_session();
    do_load();
    run_phase(LIM ? -1 : 12);
    add_word(1, 1'b0, 32'hFACE_0001);
    begin_session();
    do_load();
    run_phase(MAXC);

    for (int s = 0; s < 12; s++) begin
      int nw;
      nw = $urandom_range(1, 10);
      for (int i = 0; i < nw; i++)
        add_word($urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom);
      begin_session();
      do_load();
      run_phase($urandom_range(0, LIM ? MAXC + 5 : 15));
      idle_cycles($urandom_range(0, 3));
    end

    // Reset with a write strobe pending.
    begin_session();
    ni = 0;
    ld_valid = 1'b1;
    ld_sel   = 1'b0;
    ld_last  = 1'b0;
    ld_data  = $urandom;
    @(posedge clk);
    #1;
    chk("pend_imem_we", imem_we, 1);
    rst = 1'b0;
    #1;
    check_reset_vals("rst_load");
    ld_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Reset during RUN cycle 5.
    add_word(0, 1'b0, 32'h5555_AAAA);
    begin_session();
    do_load();
    repeat (5) @(negedge clk);
    chk("pre_rst_count", cycle_count, LIM ? 5 : 0);
    chk("pre_rst_core_rst", core_rst, 1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("rst_run");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_core_rst", core_rst, 0);
    chk("post_rst_ld_ready", ld_ready, 0);
    chk("post_rst_done", done, 0);

    // A fresh session after reset starts at address 0 again.
    add_word(0, 1'b0, 32'h0BAD_F00D);
    add_word(0, 1'b1, 32'h0BAD_CAFE);
    begin_session();
    do_load();
    run_phase(1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
